// File: rtl/uart_result_tx.sv
// uart_result_tx: 8N1 transmitter that sends a sync byte, the argmax digit and a 32-bit debug word.
// Optional XOR checksum byte is included when UART_TX_CHECKSUM_EN is defined.
module uart_result_tx #(
  parameter int CLKS_PER_BIT = 5209
) (
  input  logic        i_Clock,
  input  logic        i_Rst_L,
  input  logic        i_Start,
  input  logic [3:0]  i_Digit,
  input  logic [31:0] i_Data,
  output logic        o_TX_Serial,
  output logic        o_Busy,
  output logic        o_Done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd6;
`else
  localparam logic [2:0] LAST_BYTE = 3'd5;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [2:0]        bit_r, bit_s;
  logic [2:0]        byte_r, byte_s;
  logic [7:0]        cur_r, cur_s;
  logic [3:0]        digit_r, digit_s;
  logic [31:0]       data_r, data_s;
  logic              tx_s, busy_s, done_s;
`ifdef UART_TX_CHECKSUM_EN
  logic [7:0]        chk_r, chk_s;
`endif

  // Payload byte for a given frame position (checksum position handled by the caller).
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [3:0] digit,
                                            input logic [31:0] data);
    case (idx)
      3'd0:    frame_byte = 8'hA5;
      3'd1:    frame_byte = 8'h30 + {4'h0, digit};
      3'd2:    frame_byte = data[31:24];
      3'd3:    frame_byte = data[23:16];
      3'd4:    frame_byte = data[15:8];
      3'd5:    frame_byte = data[7:0];
      default: frame_byte = 8'h00;
    endcase
  endfunction

  // Next-state logic: bit timing, bit/byte sequencing and byte loading.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    byte_s  = byte_r;
    cur_s   = cur_r;
    digit_s = digit_r;
    data_s  = data_r;
`ifdef UART_TX_CHECKSUM_EN
    chk_s   = chk_r;
`endif
    case (state_r)
      IDLE: begin
        if (i_Start) begin
          digit_s = i_Digit;
          data_s  = i_Data;
          byte_s  = 3'd0;
          bit_s   = 3'd0;
          cnt_s   = {CNT_W{1'b0}};
          cur_s   = 8'hA5;
`ifdef UART_TX_CHECKSUM_EN
          chk_s   = 8'h00;
`endif
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == CNT_MAX) begin
          cnt_s   = {CNT_W{1'b0}};
          state_s = DATA;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_r == CNT_MAX) begin
          cnt_s = {CNT_W{1'b0}};
          if (bit_r == 3'd7) begin
            bit_s   = 3'd0;
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_r == CNT_MAX) begin
          cnt_s = {CNT_W{1'b0}};
          if (byte_r == LAST_BYTE) begin
            state_s = DONE;
          end else begin
            byte_s  = byte_r + 3'd1;
            state_s = START;
`ifdef UART_TX_CHECKSUM_EN
            // Checksum covers B1..B5 as they are loaded; B6 sends the accumulated value.
            if (byte_s == LAST_BYTE) begin
              cur_s = chk_r;
            end else begin
              cur_s = frame_byte(byte_s, digit_r, data_r);
              chk_s = chk_r ^ cur_s;
            end
`else
            cur_s = frame_byte(byte_s, digit_r, data_r);
`endif
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the upcoming state, so the outputs can be registered without extra latency.
  always_comb begin
    tx_s   = 1'b1;
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      START: begin
        tx_s   = 1'b0;
        busy_s = 1'b1;
      end
      DATA: begin
        tx_s   = cur_s[bit_s];
        busy_s = 1'b1;
      end
      STOP: begin
        tx_s   = 1'b1;
        busy_s = 1'b1;
      end
      DONE: begin
        done_s = 1'b1;
      end
      default: begin
        tx_s = 1'b1;
      end
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      bit_r       <= 3'd0;
      byte_r      <= 3'd0;
      cur_r       <= 8'h00;
      digit_r     <= 4'h0;
      data_r      <= 32'h0000_0000;
`ifdef UART_TX_CHECKSUM_EN
      chk_r       <= 8'h00;
`endif
      o_TX_Serial <= 1'b1;
      o_Busy      <= 1'b0;
      o_Done      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      bit_r       <= bit_s;
      byte_r      <= byte_s;
      cur_r       <= cur_s;
      digit_r     <= digit_s;
      data_r      <= data_s;
`ifdef UART_TX_CHECKSUM_EN
      chk_r       <= chk_s;
`endif
      o_TX_Serial <= tx_s;
      o_Busy      <= busy_s;
      o_Done      <= done_s;
    end
  end

endmodule
